// File: rtl/led_pattern_sequencer.sv
// Steps an LED bank through chase, bounce and blink animations.
// Three debounced buttons change the mode, change the speed and toggle pause.
module led_pattern_sequencer #(
  parameter int unsigned LED_W    = 8,
  parameter int unsigned DIV_BASE = 6_250_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_mode,
  input  logic             btn_speed,
  input  logic             btn_pause,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode,
  output logic [1:0]       speed,
  output logic             paused,
  output logic             step_pulse
);

  typedef enum logic [1:0] {
    ModeChaseL = 2'd0,
    ModeChaseR = 2'd1,
    ModeBounce = 2'd2,
    ModeBlink  = 2'd3
  } mode_e;

  localparam int unsigned     PreW     = (DIV_BASE > 1) ? $clog2(DIV_BASE) : 1;
  localparam logic [PreW-1:0] PreMax   = PreW'(DIV_BASE - 1);
  localparam logic            DirLeft  = 1'b0;
  localparam logic            DirRight = 1'b1;

  // Button bit order inside the vectors: {pause, speed, mode}
  logic [2:0] sync1_q, sync2_q, hist_q;
  logic [2:0] btn_ev;
  logic       mode_ev, speed_ev, pause_ev;

  logic [PreW-1:0]  pre_q, pre_d;
  logic [1:0]       stepcnt_q, stepcnt_d;
  logic [1:0]       limit_m1;
  logic             base_tick, step;
  mode_e            mode_q, mode_d, mode_nxt;
  logic [1:0]       speed_q, speed_d;
  logic             paused_q, paused_d;
  logic             dir_q, dir_d;
  logic [LED_W-1:0] led_q, led_d, entry_pat;
  logic             step_pulse_q, step_pulse_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= {btn_pause, btn_speed, btn_mode};
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign btn_ev   = sync2_q & ~hist_q;
  assign mode_ev  = btn_ev[0];
  assign speed_ev = btn_ev[1];
  assign pause_ev = btn_ev[2];

  always_comb begin
    limit_m1 = 2'd0;
    unique case (speed_q)
      2'd0:    limit_m1 = 2'd3;
      2'd1:    limit_m1 = 2'd1;
      default: limit_m1 = 2'd0;
    endcase
  end

  assign base_tick = (pre_q == PreMax) && !paused_q;
  assign step      = base_tick && (stepcnt_q == limit_m1);
  assign mode_nxt  = mode_e'(mode_q + 2'd1);

  always_comb begin
    entry_pat = LED_W'(1);
    unique case (mode_nxt)
      ModeChaseR: entry_pat = {1'b1, {(LED_W-1){1'b0}}};
      ModeBlink:  entry_pat = '1;
      default:    entry_pat = LED_W'(1);
    endcase
  end

  always_comb begin
    pre_d        = pre_q;
    stepcnt_d    = stepcnt_q;
    mode_d       = mode_q;
    speed_d      = speed_q;
    paused_d     = paused_q;
    dir_d        = dir_q;
    led_d        = led_q;
    step_pulse_d = 1'b0;

    // The prescaler freezes, rather than clears, while paused
    if (!paused_q) begin
      pre_d = (pre_q == PreMax) ? '0 : pre_q + PreW'(1);
    end
    if (base_tick) begin
      stepcnt_d = step ? 2'd0 : stepcnt_q + 2'd1;
    end

    if (step) begin
      step_pulse_d = 1'b1;
      unique case (mode_q)
        ModeChaseL: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
        ModeChaseR: led_d = {led_q[0], led_q[LED_W-1:1]};
        ModeBounce: begin
          if (dir_q == DirLeft) begin
            if (led_q[LED_W-1]) begin
              dir_d = DirRight;
              led_d = led_q >> 1;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              dir_d = DirLeft;
              led_d = led_q << 1;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        ModeBlink:  led_d = ~led_q;
        default:    led_d = led_q;
      endcase
    end

    if (speed_ev) begin
      speed_d   = (speed_q == 2'd2) ? 2'd0 : speed_q + 2'd1;
      stepcnt_d = 2'd0;
    end

    if (pause_ev) begin
      paused_d = !paused_q;
    end

    // A mode change wins over any step in the same cycle
    if (mode_ev) begin
      mode_d       = mode_nxt;
      led_d        = entry_pat;
      dir_d        = DirLeft;
      pre_d        = '0;
      stepcnt_d    = 2'd0;
      step_pulse_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q        <= '0;
      stepcnt_q    <= 2'd0;
      mode_q       <= ModeChaseL;
      speed_q      <= 2'd0;
      paused_q     <= 1'b0;
      dir_q        <= DirLeft;
      led_q        <= LED_W'(1);
      step_pulse_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      stepcnt_q    <= stepcnt_d;
      mode_q       <= mode_d;
      speed_q      <= speed_d;
      paused_q     <= paused_d;
      dir_q        <= dir_d;
      led_q        <= led_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign led        = led_q;
  assign mode       = mode_q;
  assign speed      = speed_q;
  assign paused     = paused_q;
  assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomised bench for led_pattern_sequencer: a step-count reference model feeds a
// scoreboard that is drained whenever the DUT raises step_pulse.
module tb_led_pattern_sequencer;

  localparam int LW  = 8;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn_mode = 1'b0, btn_speed = 1'b0, btn_pause = 1'b0;
  logic [LW-1:0] led;
  logic [1:0]    mode, speed;
  logic          paused, step_pulse;

  int checks = 0;
  int errors = 0;

  led_pattern_sequencer #(
    .LED_W    (LW),
    .DIV_BASE (DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_speed  (btn_speed),
    .btn_pause  (btn_pause),
    .led        (led),
    .mode       (mode),
    .speed      (speed),
    .paused     (paused),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  // Pattern as a function of the number of steps taken since the mode was entered
  function automatic logic [LW-1:0] pattern(input int md, input int n);
    logic [LW-1:0] one;
    int p;
    one = 1;
    case (md)
      0: return one << (n % LW);
      1: return (one << (LW - 1)) >> (n % LW);
      2: begin
        p = n % (2 * LW - 2);
        return one << ((p < LW) ? p : (2 * LW - 2 - p));
      end
      default: return ((n % 2) == 0) ? {LW{1'b1}} : {LW{1'b0}};
    endcase
  endfunction

  // Reference model state
  int  m_mode = 0, m_speed = 0, m_n = 0, m_pre = 0, m_k = 0;
  bit  m_paused = 0, m_pulse = 0;
  int  b1[3] = '{0, 0, 0};
  int  b2[3] = '{0, 0, 0};
  int  b3[3] = '{0, 0, 0};
  int  sb[3];
  bit  ev[3];
  bit  m_tick, m_step;
  int  m_limit;
  logic [LW+1:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_speed = 0; m_n = 0; m_pre = 0; m_k = 0;
      m_paused = 0; m_pulse = 0;
      for (int i = 0; i < 3; i++) begin
        b1[i] = 0; b2[i] = 0; b3[i] = 0;
      end
      exp_q.delete();
    end else begin
      sb = '{int'(btn_mode), int'(btn_speed), int'(btn_pause)};
      // A level seen high two edges ago but low three edges ago acts on this edge
      for (int i = 0; i < 3; i++) begin
        ev[i] = (b2[i] == 1) && (b3[i] == 0);
        b3[i] = b2[i];
        b2[i] = b1[i];
        b1[i] = sb[i];
      end
      m_limit = 4 >> m_speed;
      m_tick  = !m_paused && (m_pre == DIV - 1);
      m_step  = m_tick && (m_k + 1 == m_limit);
      if (!m_paused) m_pre = (m_pre + 1) % DIV;
      if (m_tick) m_k = m_step ? 0 : m_k + 1;
      m_pulse = m_step;
      if (m_step) m_n++;
      if (ev[1]) begin
        m_speed = (m_speed + 1) % 3;
        m_k = 0;
      end
      if (ev[2]) m_paused = !m_paused;
      if (ev[0]) begin
        m_mode = (m_mode + 1) % 4;
        m_n = 0; m_pre = 0; m_k = 0; m_pulse = 0;
      end
      if (m_pulse) exp_q.push_back({2'(m_mode), pattern(m_mode, m_n)});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [LW+1:0] got;

  // Monitor: per-cycle state comparison plus scoreboard pop on each step_pulse
  always @(posedge clk) begin
    #2;
    check("led", 32'(led), 32'(pattern(m_mode, m_n)));
    check("mode", 32'(mode), 32'(m_mode));
    check("speed", 32'(speed), 32'(m_speed));
    check("paused", 32'(paused), 32'(m_paused));
    check("step_pulse", 32'(step_pulse), 32'(m_pulse));
    if (step_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_step: got step_pulse expected no step at %0t", $time);
      end else begin
        got = exp_q.pop_front();
        check("sb_step", 32'({mode, led}), 32'(got));
      end
    end
  end

  task automatic press(input int which, input int hold, input int gap);
    @(negedge clk);
    case (which)
      0: btn_mode = 1'b1;
      1: btn_speed = 1'b1;
      default: btn_pause = 1'b1;
    endcase
    repeat (hold) @(negedge clk);
    btn_mode = 1'b0;
    btn_speed = 1'b0;
    btn_pause = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  int r;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Speed to 2, chase left across the wrap
    press(1, 6, 4);
    press(1, 6, 40);
    // CHASE_R then BOUNCE
    press(0, 5, 20);
    press(0, 5, 90);
    // Pause, mode while paused, resume in BLINK
    press(2, 5, 50);
    press(0, 5, 10);
    press(2, 5, 30);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      r = $urandom_range(0, 199);
      if (r < 4) btn_speed = ~btn_speed;
      else if (r < 7) btn_mode = ~btn_mode;
      else if (r < 10) btn_pause = ~btn_pause;
    end
    btn_mode = 1'b0;
    btn_speed = 1'b0;
    btn_pause = 1'b0;
    repeat (8) @(negedge clk);

    // Mode and speed on the same cycle, then reset mid-sequence
    btn_mode = 1'b1;
    btn_speed = 1'b1;
    repeat (6) @(negedge clk);
    btn_mode = 1'b0;
    btn_speed = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_led", 32'(led), 32'h01);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_speed", 32'(speed), 32'd0);
    check("rst_paused", 32'(paused), 32'd0);
    check("rst_pulse", 32'(step_pulse), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Controller that sequences the board's 8-LED bank through selectable animation modes at selectable speeds, with pause.
- Replaces the fixed single-pattern chaser at the top level and is driven by three debounced push-button levels.
- It contains its own prescaler and step scheduler, button edge detection, a mode FSM and the LED pattern register.

Parameters:
- LED_W, 8, number of LEDs; must be at least 2.
- DIV_BASE, 6_250_000, clk cycles per base tick; 8 Hz at 50 MHz. Benches use 4.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- btn_mode  in  1  debounced level, asynchronous to clk; a rising edge advances the mode
- btn_speed  in  1  debounced level, asynchronous; a rising edge advances the speed
- btn_pause  in  1  debounced level, asynchronous; a rising edge toggles pause
- led  out  LED_W  LED drive, registered
- mode  out  2  current mode: 0 CHASE_L, 1 CHASE_R, 2 BOUNCE, 3 BLINK
- speed  out  2  current speed level, 0..2
- paused  out  1  high while stepping is frozen
- step_pulse  out  1  high for exactly one cycle, in the cycle where led takes a new step value

Behaviour:
- Reset values, asynchronous:
  - led = 1 (LSB only), mode = CHASE_L, speed = 0, paused = 0, step_pulse = 0.
  - Prescaler, step counter, bounce direction (left), synchroniser flops and edge-history flops all clear to 0.
- Button path:
  - Each button goes through a 2-flop synchroniser, then a rising-edge detector.
  - The resulting event is a single-cycle pulse 3 cycles after the input rises.
  - A held button produces only one event.
- Prescaler:
  - Counts 0..DIV_BASE-1 and wraps.
  - base_tick = (count == DIV_BASE-1) && !paused.
  - It is held, not cleared, while paused.
- Step scheduler:
  - limit = 4, 2 or 1 base ticks for speed 0, 1 or 2.
  - The step counter increments on base_tick.
  - A step fires when base_tick && stepcnt == limit-1; stepcnt then returns to 0.
  - At speed 2 a step fires every DIV_BASE cycles. After reset the first step lands 4*DIV_BASE cycles after rst deasserts.
- Step actions (led and step_pulse register on the same edge):
  - CHASE_L: rotate left; MSB wraps to LSB.
  - CHASE_R: rotate right; LSB wraps to MSB.
  - BOUNCE, dir left: if led[LED_W-1] is set, dir becomes right and led shifts right by 1; otherwise led shifts left by 1. Dir right mirrors this using led[0].
    - Period is 2*LED_W-2 steps.
    - Sequence for LED_W=8: 01,02,...,80,40,...,01,02.
  - BLINK: led = ~led.
- Mode event:
  - mode advances 0→1→2→3→0.
  - led loads the new mode's entry pattern:
    - CHASE_L: LSB only.
    - CHASE_R: MSB only.
    - BOUNCE: LSB only, dir left.
    - BLINK: all ones.
  - Prescaler and stepcnt clear.
  - No step_pulse in that cycle.
  - Takes priority over a step that would fire in the same cycle; that step is dropped.
- Speed event:
  - speed advances 0→1→2→0.
  - stepcnt clears; the prescaler is unaffected.
  - If coincident with a step, the step still fires, and stepcnt ends at 0.
- Pause event:
  - paused toggles.
  - When pausing, led holds its value and no step_pulse occurs.
  - When resuming, counting continues from the held prescaler and stepcnt values.
- Mode event while paused: loads the entry pattern and clears the counters; paused stays 1.
- Simultaneous events in one cycle: all take effect. Mode rules override step and counter rules; speed and pause apply independently.
- Reset mid-operation: all state returns to reset values immediately; no partial step.
- Arithmetic:
  - Prescaler width is $clog2(DIV_BASE), minimum 1.
  - stepcnt is 2 bits; mode and speed wrap as stated.
  - A speed value of 3 is never produced.

Test Plan (DIV_BASE=4, LED_W=8):
- Reset, run 40 cycles: step_pulse at cycles 16 and 32 after release; led goes 01→02→04.
- Speed pressed twice (speed=2), CHASE_L: led rotates 80→01 on wrap; consecutive step_pulses exactly 4 cycles apart.
- Mode pressed once: 3 cycles after the press, mode=1, led=80, no step_pulse that cycle. At speed 2, next steps give 40, then 20.
- BOUNCE at speed 2, 20 steps observed: 02,04,...,80,40,...,01,02,..., with the direction reversal at 80 and 01 exact.
- Pause mid-run: led frozen for 50 cycles, no step_pulse. Mode pressed while paused: led=FF (BLINK), paused=1. Unpause: led alternates 00/FF every 4 cycles (speed 2).
- Mode and speed pressed on the same cycle, then rst asserted mid-sequence: both advance on the same event cycle. rst immediately returns led=01, mode=0, speed=0, paused=0.
